// File: rtl/gpio_cfg_loader.sv
// Serial configuration sequencer for the user-project IO pads.
// Fetches one word per pad, shifts the words MSB-first down the pad chain and then pulses a load strobe.
module gpio_cfg_loader #(
  parameter int unsigned NUM_IO   = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLKDIV   = 2,
  localparam int unsigned AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                start,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load
);

  localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  localparam logic [AW-1:0] LastAddr = AW'(NUM_IO - 1);
  localparam logic [BW-1:0] LastBit  = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] LastDiv  = DW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShiftLo,
    StShiftHi,
    StLoad,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CFG_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [DW-1:0]       divcnt_q, divcnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                sload_q, sload_d;
  logic                div_last;

  assign div_last = (divcnt_q == LastDiv);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    addr_d   = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = LastAddr;
          state_d = StFetch;
        end
      end
      StFetch: begin
        shreg_d  = cfg_data;
        bitcnt_d = LastBit;
        divcnt_d = '0;
        state_d  = StShiftLo;
      end
      StShiftLo: begin
        if (div_last) begin
          divcnt_d = '0;
          state_d  = StShiftHi;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      StShiftHi: begin
        if (div_last) begin
          divcnt_d = '0;
          shreg_d  = shreg_q << 1;
          if (bitcnt_q != '0) begin
            bitcnt_d = bitcnt_q - BW'(1);
            state_d  = StShiftLo;
          end else if (addr_q != '0) begin
            addr_d  = addr_q - AW'(1);
            state_d = StFetch;
          end else begin
            state_d = StLoad;
          end
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      StLoad: begin
        if (div_last) begin
          divcnt_d = '0;
          state_d  = StDone;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    sclk_d  = (state_d == StShiftHi);
    sload_d = (state_d == StLoad);
    sdata_d = 1'b0;
    if ((state_d == StShiftLo) || (state_d == StShiftHi)) begin
      sdata_d = shreg_d[CFG_BITS-1];
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sload_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      sload_q  <= sload_d;
    end
  end

  assign cfg_addr     = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdata_q;
  assign serial_load  = sload_q;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: a small (2 pads, 4 bits, div 1) and a default-sized instance.
// Expected serial bits are queued at start and popped on each serial_clock rising edge.
module tb_gpio_cfg_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Small instance
  logic       s_rst, s_start, s_busy, s_done, s_sclk, s_sdata, s_sload;
  logic [0:0] s_addr;
  logic [3:0] s_data;
  logic [3:0] words_s [2];
  logic       corrupt = 1'b0;
  int         cyc_s = 0;
  logic       s_is_fetch;

  gpio_cfg_loader #(.NUM_IO(2), .CFG_BITS(4), .CLKDIV(1)) u_small (
    .clock        (clock),
    .resetb       (s_rst),
    .start        (s_start),
    .cfg_addr     (s_addr),
    .cfg_data     (s_data),
    .busy         (s_busy),
    .done         (s_done),
    .serial_clock (s_sclk),
    .serial_data  (s_sdata),
    .serial_load  (s_sload)
  );

  // Bench-side schedule: fetches happen at busy cycles 0 and 9 of a small run.
  always @(posedge clock) cyc_s <= s_busy ? cyc_s + 1 : 0;
  assign s_is_fetch = s_busy && ((cyc_s == 0) || (cyc_s == 9));
  assign s_data = (!corrupt || s_is_fetch) ? words_s[s_addr] :
                  (cyc_s[0] ? ~words_s[s_addr] : (words_s[s_addr] ^ 4'h6));

  // Default instance
  logic        d_rst, d_start, d_busy, d_done, d_sclk, d_sdata, d_sload;
  logic [5:0]  d_addr;
  logic [12:0] d_data;
  assign d_data = 13'h1803;

  gpio_cfg_loader u_dflt (
    .clock        (clock),
    .resetb       (d_rst),
    .start        (d_start),
    .cfg_addr     (d_addr),
    .cfg_data     (d_data),
    .busy         (d_busy),
    .done         (d_done),
    .serial_clock (d_sclk),
    .serial_data  (d_sdata),
    .serial_load  (d_sload)
  );

  logic q_s[$];
  logic q_d[$];
  logic [0:0] addr_log[$];

  int s_edges, s_busy_cnt, s_load_cnt, s_done_cnt, s_overlap, s_load_done;
  int d_edges, d_busy_cnt, d_load_cnt, d_done_cnt, d_overlap;

  task automatic clr_s();
    s_edges = 0; s_busy_cnt = 0; s_load_cnt = 0; s_done_cnt = 0;
    s_overlap = 0; s_load_done = 0;
    addr_log.delete();
  endtask

  task automatic push_s();
    for (int p = 1; p >= 0; p--)
      for (int b = 3; b >= 0; b--) q_s.push_back(words_s[p][b]);
  endtask

  task automatic pulse_s();
    @(negedge clock);
    s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
  endtask

  task automatic wait_done_s();
    for (int i = 0; i < 60 && s_done_cnt == 0; i++) @(negedge clock);
    repeat (5) @(negedge clock);
  endtask

  // Small monitor
  initial begin
    logic prev_sclk = 1'b0;
    logic prev_load = 1'b0;
    forever begin
      @(negedge clock);
      if (s_sclk && !prev_sclk) begin
        s_edges++;
        if (q_s.size() == 0) check("s_extra_bit", 32'(q_s.size()), 32'd1);
        else check("s_bit", 32'(s_sdata), 32'(q_s.pop_front()));
      end
      if (s_busy) s_busy_cnt++;
      if (s_sload) s_load_cnt++;
      if (s_done) s_done_cnt++;
      if (s_sload && s_sclk) s_overlap++;
      if (s_done && prev_load) s_load_done++;
      if (s_busy && (addr_log.size() == 0 || addr_log[$] != s_addr)) addr_log.push_back(s_addr);
      prev_sclk = s_sclk;
      prev_load = s_sload;
    end
  end

  // Default monitor, including phase-length checks
  initial begin
    logic prev_sclk = 1'b0;
    int   hi_len = 0;
    int   lo_len = 0;
    forever begin
      @(negedge clock);
      if (d_sclk && !prev_sclk) begin
        // First bit of each pad follows a FETCH cycle, so its low phase is one longer.
        check("d_lo_phase", 32'(lo_len), ((d_edges % 13) == 0) ? 32'd3 : 32'd2);
        lo_len = 0;
        d_edges++;
        if (q_d.size() == 0) check("d_extra_bit", 32'(q_d.size()), 32'd1);
        else check("d_bit", 32'(d_sdata), 32'(q_d.pop_front()));
      end
      if (!d_sclk && prev_sclk) begin
        check("d_hi_phase", 32'(hi_len), 32'd2);
        hi_len = 0;
      end
      if (d_sclk) hi_len++;
      else if (d_busy) lo_len++;
      if (!d_busy) lo_len = 0;
      if (d_busy) d_busy_cnt++;
      if (d_sload) d_load_cnt++;
      if (d_done) d_done_cnt++;
      if (d_sload && d_sclk) d_overlap++;
      prev_sclk = d_sclk;
    end
  end

  initial begin
    logic [12:0] w;
    words_s[1] = 4'hA;
    words_s[0] = 4'h3;
    s_rst = 1'b0; s_start = 1'b1;
    d_rst = 1'b0; d_start = 1'b1;
    clr_s();
    d_edges = 0; d_busy_cnt = 0; d_load_cnt = 0; d_done_cnt = 0; d_overlap = 0;

    // Reset held with start asserted
    repeat (3) @(negedge clock);
    check("rst_s_outs", 32'({s_addr, s_busy, s_done, s_sclk, s_sdata, s_sload}), 32'd0);
    check("rst_d_outs", 32'({d_addr, d_busy, d_done, d_sclk, d_sdata, d_sload}), 32'd0);
    s_start = 1'b0; d_start = 1'b0;
    s_rst = 1'b1; d_rst = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_s_busy", 32'(s_busy), 32'd0);
    check("idle_d_busy", 32'(d_busy), 32'd0);

    // Basic small load
    clr_s();
    push_s();
    pulse_s();
    wait_done_s();
    check("t2_edges", 32'(s_edges), 32'd8);
    check("t2_busy_len", 32'(s_busy_cnt), 32'd20);
    check("t2_load_len", 32'(s_load_cnt), 32'd1);
    check("t2_done_cnt", 32'(s_done_cnt), 32'd1);
    check("t2_load_then_done", 32'(s_load_done), 32'd1);
    check("t2_overlap", 32'(s_overlap), 32'd0);
    check("t2_queue_left", 32'(q_s.size()), 32'd0);
    check("t2_addr_steps", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("t2_addr_first", 32'(addr_log[0]), 32'd1);
      check("t2_addr_second", 32'(addr_log[1]), 32'd0);
    end

    // Start pulses while busy and in the DONE cycle are ignored
    clr_s();
    push_s();
    pulse_s();
    repeat (4) @(negedge clock);
    pulse_s();
    repeat (4) @(negedge clock);
    pulse_s();
    for (int i = 0; i < 40 && !s_done; i++) @(negedge clock);
    s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    repeat (10) @(negedge clock);
    check("t4_edges", 32'(s_edges), 32'd8);
    check("t4_busy_len", 32'(s_busy_cnt), 32'd20);
    check("t4_done_cnt", 32'(s_done_cnt), 32'd1);
    check("t4_queue_left", 32'(q_s.size()), 32'd0);
    check("t4_idle", 32'(s_busy), 32'd0);

    // cfg_data toggling outside FETCH must not reach the chain
    corrupt = 1'b1;
    clr_s();
    push_s();
    pulse_s();
    wait_done_s();
    corrupt = 1'b0;
    check("t6_edges", 32'(s_edges), 32'd8);
    check("t6_queue_left", 32'(q_s.size()), 32'd0);

    // Reset in the middle of pad 0
    clr_s();
    push_s();
    pulse_s();
    repeat (14) @(negedge clock);
    s_rst = 1'b0;
    #1;
    check("t5_rst_outs", 32'({s_addr, s_busy, s_done, s_sclk, s_sdata, s_sload}), 32'd0);
    q_s.delete();
    repeat (3) @(negedge clock);
    check("t5_no_load", 32'(s_load_cnt), 32'd0);
    check("t5_no_done", 32'(s_done_cnt), 32'd0);
    s_rst = 1'b1;
    repeat (2) @(negedge clock);
    clr_s();
    push_s();
    pulse_s();
    wait_done_s();
    check("t5_edges", 32'(s_edges), 32'd8);
    check("t5_done_cnt", 32'(s_done_cnt), 32'd1);
    check("t5_busy_len", 32'(s_busy_cnt), 32'd20);
    check("t5_queue_left", 32'(q_s.size()), 32'd0);

    // Default parameters, with ignored starts at busy cycles 5 and 100
    w = 13'h1803;
    for (int p = 0; p < 38; p++)
      for (int b = 12; b >= 0; b--) q_d.push_back(w[b]);
    @(negedge clock);
    d_start = 1'b1;
    @(negedge clock);
    d_start = 1'b0;
    repeat (4) @(negedge clock);
    d_start = 1'b1;
    @(negedge clock);
    d_start = 1'b0;
    repeat (94) @(negedge clock);
    d_start = 1'b1;
    @(negedge clock);
    d_start = 1'b0;
    for (int i = 0; i < 2100 && d_done_cnt == 0; i++) @(negedge clock);
    repeat (10) @(negedge clock);
    check("t3_edges", 32'(d_edges), 32'd494);
    check("t3_busy_len", 32'(d_busy_cnt), 32'd2017);
    check("t3_done_cnt", 32'(d_done_cnt), 32'd1);
    check("t3_load_len", 32'(d_load_cnt), 32'd2);
    check("t3_overlap", 32'(d_overlap), 32'd0);
    check("t3_queue_left", 32'(q_d.size()), 32'd0);
    check("t3_idle", 32'(d_busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
